tc_scan_ctrl: RTL and testbench
===============================

# tc_scan_ctrl

Time-constant scan controller for the theremin antenna front end. It sequences the charge/discharge excitation of up to N_CH antennas (pitch, volume, ...) round-robin, and shares one capture counter among them. It measures the cycles from charge start to the comparator rising edge and emits one tagged result per antenna per scan slot. It sits between the antenna pins and the downstream pitch/volume filtering logic.

## Interface
- D_BITS, 12, width of measured count and out_data
- N_CH, 2, number of antennas scanned (2..8)
- DISCH_CYC, 300, discharge/blanking cycles before each measurement (≥4)
- CH_W, derived, max(1, $clog2(N_CH)), not overridable

- clk_100  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  run scanning; sampled at slot boundaries
- ch_mask  in  N_CH  per-antenna scan enable; sampled at slot boundaries
- ant_out  out  N_CH  excitation drive; 1 = charge, 0 = discharge
- ant_in  in  N_CH  asynchronous comparator inputs
- out_data  out  D_BITS  measured count
- out_ch  out  CH_W  antenna index of the result
- out_status  out  2  00 ok, 01 timeout, 10 stuck-high
- out_valid  out  1  one-cycle result strobe
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, DISCHARGE, MEASURE, RESULT.
- IDLE: ant_out = 0. If enable and ch_mask != 0, select the next channel and go to DISCHARGE.
- Channel select: the lowest-index set bit of ch_mask above the current channel, wrapping around. After reset the current channel is N_CH-1, so channel 0 is selected first.
- DISCHARGE: all ant_out = 0 for exactly DISCH_CYC cycles. Rising edges are ignored, which provides bounce blanking. In the last cycle, check the synchronized ant_in[ch]:
  - high: capture out_data = 0, status 10, go to RESULT.
  - low: go to MEASURE.
- MEASURE: ant_out[ch] = 1, all others 0. The counter starts at 0 on entry and increments every cycle.
  - On the synchronized rising edge of ant_in[ch]: capture the counter value, status 00.
  - Else, if the counter equals 2^D_BITS-1: capture all-ones, status 01.
  - If both occur in the same cycle, the edge wins.
  - Either outcome goes to RESULT.
- RESULT: ant_out = 0, out_valid = 1 for one cycle, out_ch = ch.
  - Then, if enable and ch_mask != 0, select the next channel and go to DISCHARGE.
  - Otherwise go to IDLE.
- Edge detection: 3-flop chain per channel (s1, s2, s3). rise = s2 & ~s3. The chain runs continuously in every state.
- Counter is D_BITS wide, saturates, never wraps.
- Deasserting enable or changing ch_mask never aborts a slot; the change takes effect at the next selection.
- A mask with a single set bit re-selects the same channel every slot.

## Timing
- Reset values: ant_out 0, out_data 0, out_ch 0, out_status 00, out_valid 0, busy 0, FSM IDLE, channel N_CH-1, sync flops 0.
- Reset mid-slot drops ant_out to 0 on the next edge and discards the partial result.
- All outputs are registered.
- IDLE→DISCHARGE takes one cycle after enable is seen.
- Slot length is DISCH_CYC + M + 1 cycles, where M is the cycles spent in MEASURE (capture cycle included).
- Capture offset: zero-delay loopback (ant_in = ant_out) captures 2; each extra cycle of comparator delay adds 1.
- out_data, out_ch and out_status are valid with out_valid and hold until the next result.

## Structure
- Package tc_scan_pkg holds:
  - the state enum;
  - status constants ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_STUCK = 2'b10.
- Sub-module tc_in_sync: per-channel synchronizer with edge detect. Inputs clk_100, reset, async_in; outputs level (s2) and rise. Instantiated N_CH times.
- Round-robin selection is a combinational function in the top module.

## Test plan
- Loopback ch0 with 0 cycles of delay, mask 01, enable → out_valid after 300+3 cycles from DISCHARGE entry; out_data 2, out_ch 0, status 00.
- Mask 11, ch0 delay 100, ch1 delay 500 → alternating results: ch0 = 102, ch1 = 502, ch0 = 102. ant_out is never high on both channels at once.
- ant_in[1] tied low, D_BITS = 8 → ch1 result 255, status 01, after exactly 256 MEASURE cycles.
- ant_in[0] held high → result 0, status 10, no ant_out[0] pulse. Scanning continues to ch1.
- Enable dropped mid-MEASURE → that slot completes with a valid result, then IDLE with busy 0 and ant_out 0.
- Reset asserted mid-MEASURE → next cycle all outputs at reset values. After release, the first slot is ch0.

Source files
------------

// File: rtl/tc_scan_ctrl_pkg.sv
// tc_scan_pkg: shared types and constants for the theremin time-constant scan
// controller.
//   state_e    - scan FSM state encoding
//   ST_OK      - result captured on a comparator rising edge
//   ST_TIMEOUT - counter reached all-ones without an edge
//   ST_STUCK   - comparator already high at the end of discharge
package tc_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DISCHARGE = 2'd1,
    S_MEASURE   = 2'd2,
    S_RESULT    = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_STUCK   = 2'b10;

endpackage

// File: rtl/tc_scan_ctrl_in_sync.sv
// tc_in_sync: three-flop synchronizer with rising-edge detect for one
// asynchronous comparator input. The chain runs in every controller state.
//   clk_100  in   system clock
//   reset    in   synchronous active-high reset (clears the chain)
//   async_in in   raw comparator input
//   level    out  synchronized level (second flop)
//   rise     out  one-cycle pulse on a synchronized rising edge
module tc_in_sync (
  input  logic clk_100,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain; s3 only serves the edge detector.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/tc_scan_ctrl.sv
// tc_scan_ctrl: round-robin charge/discharge excitation of up to N_CH antennas
// with one shared capture counter measuring charge start to comparator edge.
//   clk_100    in   system clock
//   reset      in   synchronous active-high reset
//   enable     in   run scanning (sampled when a channel is selected)
//   ch_mask    in   per-antenna scan enable (sampled when a channel is selected)
//   ant_out    out  excitation drive, 1 = charge
//   ant_in     in   asynchronous comparator inputs
//   out_data   out  measured count
//   out_ch     out  antenna index of the result
//   out_status out  ST_OK / ST_TIMEOUT / ST_STUCK
//   out_valid  out  one-cycle result strobe
//   busy       out  FSM not idle
module tc_scan_ctrl
  import tc_scan_pkg::*;
#(
  parameter int  D_BITS    = 12,
  parameter int  N_CH      = 2,
  parameter int  DISCH_CYC = 300,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [N_CH-1:0]   ant_out,
  input  logic [N_CH-1:0]   ant_in,
  output logic [D_BITS-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [1:0]        out_status,
  output logic              out_valid,
  output logic              busy
);

  localparam int                DC_W     = $clog2(DISCH_CYC);
  localparam logic [DC_W-1:0]   DC_LAST  = DC_W'(DISCH_CYC - 1);
  localparam logic [D_BITS-1:0] CNT_MAX  = {D_BITS{1'b1}};
  localparam logic [N_CH-1:0]   ANT_ONE  = {{(N_CH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic [D_BITS-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]     ant_q, ant_d;
  logic [D_BITS-1:0]   data_q, data_d;
  logic [CH_W-1:0]     och_q, och_d;
  logic [1:0]          stat_q, stat_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [N_CH-1:0]     sync_level;
  logic [N_CH-1:0]     sync_rise;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    tc_in_sync u_sync (
      .clk_100  (clk_100),
      .reset    (reset),
      .async_in (ant_in[g]),
      .level    (sync_level[g]),
      .rise     (sync_rise[g])
    );
  end

  // Lowest set mask bit strictly above cur, else wrap to the lowest set bit
  // (which may be cur itself for a single-bit mask).
  function automatic logic [CH_W-1:0] next_ch(input logic [N_CH-1:0] mask,
                                              input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] sel;
    logic            found;
    sel   = cur;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && mask[k] && (k > int'(cur))) begin
        sel   = CH_W'(k);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (!found && mask[k]) begin
        sel   = CH_W'(k);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // Scan FSM next state, channel selection, counters and result capture.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE, S_RESULT: begin
        if (enable && (ch_mask != '0)) begin
          ch_d    = next_ch(ch_mask, ch_q);
          dcnt_d  = '0;
          state_d = S_DISCHARGE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DISCHARGE: begin
        // Edges are ignored here; only the level at the last cycle matters.
        if (dcnt_q == DC_LAST) begin
          if (sync_level[ch_q]) begin
            data_d  = '0;
            stat_d  = ST_STUCK;
            state_d = S_RESULT;
          end else begin
            cnt_d   = '0;
            state_d = S_MEASURE;
          end
        end else begin
          dcnt_d = dcnt_q + DC_W'(1);
        end
      end
      S_MEASURE: begin
        // Edge takes priority over timeout when both land in one cycle.
        if (sync_rise[ch_q]) begin
          data_d  = cnt_q;
          stat_d  = ST_OK;
          state_d = S_RESULT;
        end else if (cnt_q == CNT_MAX) begin
          data_d  = CNT_MAX;
          stat_d  = ST_TIMEOUT;
          state_d = S_RESULT;
        end else begin
          cnt_d = cnt_q + D_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    ant_d   = '0;
    valid_d = 1'b0;
    och_d   = och_q;
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_MEASURE) begin
      ant_d = ANT_ONE << ch_d;
    end else begin
      ant_d = '0;
    end
    if (state_d == S_RESULT) begin
      valid_d = 1'b1;
      och_d   = ch_d;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= CH_W'(N_CH - 1);
      dcnt_q  <= '0;
      cnt_q   <= '0;
      ant_q   <= '0;
      data_q  <= '0;
      och_q   <= '0;
      stat_q  <= ST_OK;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      ant_q   <= ant_d;
      data_q  <= data_d;
      och_q   <= och_d;
      stat_q  <= stat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ant_out    = ant_q;
  assign out_data   = data_q;
  assign out_ch     = och_q;
  assign out_status = stat_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tc_scan_ctrl.sv
// tb_tc_scan_ctrl: scoreboard bench for tc_scan_ctrl. Each antenna is modelled
// as tied low, tied high, or a loopback of its drive delayed by N cycles.
module tb_tc_scan_ctrl;

  localparam int D_BITS = 8;
  localparam int N_CH   = 3;
  localparam int DISCH  = 300;
  localparam int CH_W   = 2;
  localparam int MAXCNT = (1 << D_BITS) - 1;

  localparam int M_LOOP = 0;
  localparam int M_LOW  = 1;
  localparam int M_HIGH = 2;

  typedef struct {
    int ch;
    int data;
    int st;
    int gap;
    int start;
  } exp_t;

  logic              clk_100 = 1'b0;
  logic              reset;
  logic              enable;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH-1:0]   ant_out;
  logic [N_CH-1:0]   ant_in;
  logic [D_BITS-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic [1:0]        out_status;
  logic              out_valid;
  logic              busy;

  int   mode [N_CH];
  int   dly  [N_CH];
  logic [263:0] dl [N_CH];
  exp_t sb[$];
  int   cyc = 0;
  int   compares = 0;
  int   mism = 0;
  int   cur_ch = N_CH - 1;
  int   prev_cyc = 0;
  int   h_data = 0;
  int   h_ch = 0;
  int   h_st = 0;

  tc_scan_ctrl #(.D_BITS(D_BITS), .N_CH(N_CH), .DISCH_CYC(DISCH)) dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .enable     (enable),
    .ch_mask    (ch_mask),
    .ant_out    (ant_out),
    .ant_in     (ant_in),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_status (out_status),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clk_100 = ~clk_100;

  always @(posedge clk_100) cyc <= cyc + 1;

  // Per-channel history of the drive, used for delayed loopback.
  always @(posedge clk_100) begin
    for (int c = 0; c < N_CH; c++) begin
      if (reset) dl[c] <= '0;
      else       dl[c] <= {dl[c][262:0], ant_out[c]};
    end
  end

  always_comb begin
    ant_in = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (mode[c] == M_LOW)       ant_in[c] = 1'b0;
      else if (mode[c] == M_HIGH) ant_in[c] = 1'b1;
      else if (dly[c] == 0)       ant_in[c] = ant_out[c];
      else                        ant_in[c] = dl[c][dly[c]-1];
    end
  end

  task automatic chk(input string name, input int act, input int req);
    compares++;
    if (act != req) begin
      mism++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Round robin: walk upward from cur with wrap until a masked-in channel.
  function automatic int rr_next(input logic [N_CH-1:0] m, input int cur);
    int n = cur;
    for (int i = 0; i < N_CH; i++) begin
      n = (n + 1) % N_CH;
      if (m[n]) return n;
    end
    return cur;
  endfunction

  // Expected result and MEASURE length for one slot of channel c.
  function automatic void slot_model(input int c, output int data, output int st,
                                     output int m);
    if (mode[c] == M_HIGH) begin
      data = 0; st = 2; m = 0;
    end else if (mode[c] == M_LOW || (2 + dly[c]) > MAXCNT) begin
      data = MAXCNT; st = 1; m = MAXCNT + 1;
    end else begin
      data = 2 + dly[c]; st = 0; m = 3 + dly[c];
    end
  endfunction

  // Monitor: pops the scoreboard on each strobe, checks hold and drive rules.
  always @(negedge clk_100) begin
    exp_t e;
    if (reset) begin
      h_data = 0; h_ch = 0; h_st = 0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_ch", int'(out_ch), e.ch);
          chk("res_data", int'(out_data), e.data);
          chk("res_status", int'(out_status), e.st);
          if (e.start >= 0) chk("first_latency", cyc - e.start, e.gap);
          else              chk("slot_gap", cyc - prev_cyc, e.gap);
          prev_cyc = cyc;
          h_data = e.data; h_ch = e.ch; h_st = e.st;
        end
      end else begin
        chk("hold_data", int'(out_data), h_data);
        chk("hold_ch", int'(out_ch), h_ch);
        chk("hold_status", int'(out_status), h_st);
      end
      chk("ant_onehot", int'($countones(ant_out) <= 1), 1);
      if (!busy) chk("idle_ant", int'(ant_out), 0);
      for (int c = 0; c < N_CH; c++)
        if (mode[c] == M_HIGH) chk("stuck_no_drive", int'(ant_out[c]), 0);
    end
  end

  task automatic run_phase(input logic [N_CH-1:0] m, input int k);
    exp_t e;
    int c, lm, seen, w, t;
    @(negedge clk_100);
    ch_mask = m;
    enable  = 1'b1;
    c  = cur_ch;
    lm = 0;
    for (int i = 0; i < k; i++) begin
      c = rr_next(m, c);
      slot_model(c, e.data, e.st, lm);
      e.ch    = c;
      e.gap   = DISCH + lm + 1;
      e.start = (i == 0) ? cyc : -1;
      sb.push_back(e);
    end
    cur_ch = c;
    seen = 0;
    t    = 0;
    while (seen < k - 1 && t < k * 700) begin
      @(negedge clk_100);
      t++;
      if (out_valid) seen++;
    end
    // Drop enable somewhere inside the last slot (discharge or measure).
    w = $urandom_range(1, DISCH + lm - 1);
    repeat (w) @(negedge clk_100);
    enable = 1'b0;
    t = 0;
    while ((busy || sb.size() != 0) && t < 2000) begin
      @(negedge clk_100);
      t++;
    end
    chk("phase_drain", sb.size(), 0);
    chk("idle_busy", int'(busy), 0);
    sb.delete();
    repeat (3) @(negedge clk_100);
  endtask

  task automatic set_ch(input int c, input int md, input int d);
    mode[c] = md;
    dly[c]  = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ant_out"}, int'(ant_out), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_ch"}, int'(out_ch), 0);
    chk({tag, "_out_status"}, int'(out_status), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish by cycle 90000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N_CH-1:0] rm;
    int r;
    reset   = 1'b1;
    enable  = 1'b0;
    ch_mask = '0;
    repeat (4) @(negedge clk_100);
    chk_reset_vals("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk_100);

    // Enable with an empty mask keeps the controller idle.
    enable = 1'b1;
    repeat (20) @(negedge clk_100);
    chk("empty_mask_busy", int'(busy), 0);
    enable = 1'b0;

    // Zero-delay loopback on ch0 only: capture 2, same channel every slot.
    set_ch(0, M_LOOP, 0); set_ch(1, M_LOOP, 0); set_ch(2, M_LOOP, 0);
    run_phase(3'b001, 2);

    // Two loopbacks with different delays alternate.
    set_ch(0, M_LOOP, 100); set_ch(1, M_LOOP, 200);
    run_phase(3'b011, 3);

    // Tied-low channel times out after the full counter range.
    set_ch(1, M_LOW, 0);
    run_phase(3'b010, 2);

    // Stuck-high channel reports immediately and scanning moves on.
    set_ch(0, M_HIGH, 0); set_ch(1, M_LOOP, 5);
    run_phase(3'b011, 3);

    // Edge on the final count wins; one cycle later is a timeout.
    set_ch(0, M_LOOP, 254); set_ch(2, M_LOOP, 253);
    run_phase(3'b101, 3);

    // Reset in the middle of MEASURE discards the slot.
    set_ch(0, M_LOOP, 150);
    @(negedge clk_100);
    ch_mask = 3'b001;
    enable  = 1'b1;
    repeat (DISCH + 20) @(negedge clk_100);
    chk("pre_reset_drive", int'(ant_out[0]), 1);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk_100);
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    cur_ch = N_CH - 1;
    sb.delete();
    repeat (3) @(negedge clk_100);
    set_ch(0, M_LOOP, 7); set_ch(1, M_LOOP, 9); set_ch(2, M_LOOP, 11);
    run_phase(3'b111, 2);

    // Randomized phases.
    for (int p = 0; p < 14; p++) begin
      for (int c = 0; c < N_CH; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      set_ch(c, M_LOW, 0);
        else if (r == 1) set_ch(c, M_HIGH, 0);
        else             set_ch(c, M_LOOP, $urandom_range(0, 260));
      end
      rm = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      run_phase(rm, $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
